// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the MEM stage and a word-wide data RAM
// with a 1-cycle registered read. Handles byte/half/word loads with sign or zero
// extension, sub-word stores by read-modify-write, and flags bad accesses.
// Optional feature macro: LSU_BOUNDS_CHECK_EN (reject addresses past DEPTH_WORDS).
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, RESP} state_t;

  state_t      state, state_nxt;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_addr;
  logic [15:0] lat_wdata;

  logic        req_ready_nxt;
  logic        resp_valid_nxt;
  logic [31:0] resp_rdata_nxt;
  logic        resp_err_nxt;
  logic        mem_wen_nxt;
  logic        mem_ren_nxt;
  logic [31:0] mem_addr_nxt;
  logic [31:0] mem_wdata_nxt;

  logic        accept_c;
  logic        oob_c;
  logic        req_err_c;
  logic [7:0]  rd_byte_c;
  logic [15:0] rd_half_c;
  logic [31:0] load_ext_c;
  logic [31:0] merged_c;

  assign accept_c = req_valid && req_ready;

  // Range check folds away when the bounds feature is compiled out.
  assign oob_c = BOUNDS_EN && (32'(req_addr[31:2]) >= DEPTH_WORDS);

  // Request error: illegal size, misaligned half/word, or out of range.
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      SZ_BYTE: req_err_c = 1'b0;
      SZ_HALF: req_err_c = req_addr[0];
      SZ_WORD: req_err_c = (req_addr[1:0] != 2'b00);
      default: req_err_c = 1'b1;
    endcase
    if (oob_c) req_err_c = 1'b1;
  end

  // Lane selection and extension of the RAM read word for loads.
  always_comb begin
    rd_byte_c  = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
    rd_half_c  = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext_c = mem_rdata;
    case (lat_size)
      SZ_BYTE: load_ext_c = lat_unsigned ? {24'h0, rd_byte_c}
                                         : {{24{rd_byte_c[7]}}, rd_byte_c};
      SZ_HALF: load_ext_c = lat_unsigned ? {16'h0, rd_half_c}
                                         : {{16{rd_half_c[15]}}, rd_half_c};
      default: load_ext_c = mem_rdata;
    endcase
  end

  // Merge store data into the read word at the addressed lane.
  always_comb begin
    merged_c = mem_rdata;
    if (lat_size == SZ_BYTE) begin
      merged_c[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    end else begin
      merged_c[{lat_addr[1], 4'b0000} +: 16] = lat_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt      = state;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = 32'h0;
    resp_err_nxt   = 1'b0;
    mem_wen_nxt    = 1'b0;
    mem_ren_nxt    = 1'b0;
    mem_addr_nxt   = 32'h0;
    mem_wdata_nxt  = 32'h0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (req_err_c) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_nxt     = WR;
            mem_wen_nxt   = 1'b1;
            mem_addr_nxt  = {req_addr[31:2], 2'b00};
            mem_wdata_nxt = req_wdata;
          end else begin
            state_nxt    = RD;
            mem_ren_nxt  = 1'b1;
            mem_addr_nxt = {req_addr[31:2], 2'b00};
          end
        end
      end
      RD: state_nxt = RDWAIT;
      RDWAIT: begin
        if (lat_we) begin
          state_nxt     = WR;
          mem_wen_nxt   = 1'b1;
          mem_addr_nxt  = {lat_addr[31:2], 2'b00};
          mem_wdata_nxt = merged_c;
        end else begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = load_ext_c;
        end
      end
      WR: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    req_ready_nxt = (state_nxt == IDLE);
  end

  // Registered outputs; reset clears any in-flight RAM strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      mem_wen    <= mem_wen_nxt;
      mem_ren    <= mem_ren_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  // Request fields captured on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 16'h0;
    end else if (accept_c) begin
      lat_we       <= req_we;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a byte-level reference memory predicts every
// response and every RAM strobe; monitors pop and compare when the DUT presents them.
module tb_dmem_lsu;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  dmem_lsu #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int edge_no; } resp_t;
  typedef struct { logic wr; int edge_no; logic [31:0] addr; logic [31:0] wdata; } memop_t;

  resp_t       sb[$];
  memop_t      mq[$];
  logic [31:0] ram     [0:4095];
  logic [31:0] ref_mem [0:4095];
  int          e = 0;
  int          checks = 0;
  int          failures = 0;
  bit          prev_resp = 1'b0;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
  end

  // RAM with registered read and word writes.
  always @(posedge clk) begin
    if (mem_wen === 1'b1) ram[mem_addr[13:2]] <= mem_wdata;
    if (mem_ren === 1'b1) mem_rdata <= ram[mem_addr[13:2]];
  end

  always @(posedge clk) e <= e + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_resp) check("ready_after_resp", {31'h0, req_ready}, 32'h1);
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          resp_t r;
          r = sb.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          check("resp_latency", 32'(e), 32'(r.edge_no));
        end
      end
      prev_resp = (resp_valid === 1'b1);
    end else begin
      prev_resp = 1'b0;
    end
  end

  // RAM-strobe monitor.
  always @(negedge clk) begin
    if (mem_ren === 1'b1 || mem_wen === 1'b1) begin
      check("ren_wen_exclusive", {31'h0, mem_ren & mem_wen}, 32'h0);
      if (mq.size() == 0) begin
        check("unexpected_mem_op", {30'h0, mem_wen, mem_ren}, 32'h0);
      end else begin
        memop_t m;
        m = mq.pop_front();
        check("mem_op_kind", {31'h0, mem_wen}, {31'h0, m.wr});
        check("mem_op_edge", 32'(e), 32'(m.edge_no));
        check("mem_addr", mem_addr, m.addr);
        if (m.wr) check("mem_wdata", mem_wdata, m.wdata);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) check("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  // Drive one request and push the model's predictions.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    int e0;
    int sh;
    logic [31:0] idx, old, val, mask, nv, aligned;
    bit err;
    wait_ready(ok);
    if (!ok) return;
    e0 = e;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr;  req_wdata = wdata;
    idx     = (addr >> 2) & 32'hFFF;
    aligned = addr & 32'hFFFF_FFFC;
    sh      = 8 * int'(addr % 4);
    old     = ref_mem[idx];
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && (addr % 4) != 0) || (BOUNDS && (addr >> 2) >= 1024);
    if (err) begin
      sb.push_back('{32'h0, 1'b1, e0 + 1});
    end else if (!we) begin
      mq.push_back('{1'b0, e0 + 1, aligned, 32'h0});
      if (size == 2'd0) begin
        val = (old >> sh) & 32'hFF;
        if (!uns && val >= 128) val = val | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        val = (old >> sh) & 32'hFFFF;
        if (!uns && val >= 32'h8000) val = val | 32'hFFFF_0000;
      end else begin
        val = old;
      end
      sb.push_back('{val, 1'b0, e0 + 3});
    end else if (size == 2'd2) begin
      mq.push_back('{1'b1, e0 + 1, aligned, wdata});
      ref_mem[idx] = wdata;
      sb.push_back('{32'h0, 1'b0, e0 + 2});
    end else begin
      mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      nv   = (old & ~mask) | ((wdata << sh) & mask);
      mq.push_back('{1'b0, e0 + 1, aligned, 32'h0});
      mq.push_back('{1'b1, e0 + 3, aligned, nv});
      ref_mem[idx] = nv;
      sb.push_back('{32'h0, 1'b0, e0 + 4});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int e0;
    logic [31:0] a;
    logic [1:0]  s;
    int          r;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_strobes", {29'h0, resp_valid, mem_wen, mem_ren}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // Word store then word load.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Sub-word loads with sign and zero extension.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80F17F01);
    issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);

    // Read-modify-write stores.
    issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA);
    issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);

    // Misaligned and illegal size.
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h05, 32'h1234);
    issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);

    // Reset in the N+2 cycle of a byte store.
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);
    wait_ready(ok);
    e0 = e;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h55;
    mq.push_back('{1'b0, e0 + 1, 32'h40, 32'h0});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("busy_before_rst", {31'h0, req_ready}, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_mid_strobes", {29'h0, resp_valid, mem_wen, mem_ren}, 32'h0);
    check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    mq.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", {31'h0, req_ready}, 32'h1);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

    // Bounds: word 1024.
    issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);

    // Randomized traffic over a small window for frequent aliasing.
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 255));
      r = $urandom_range(0, 7);
      s = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      if (s == 2'd2 && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      if (s == 2'd1 && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFE;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Drain outstanding expectations.
    for (int n = 0; n < 20 && (sb.size() != 0 || mq.size() != 0); n++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    check("mq_drained", 32'(mq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
